// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and types for the checked adder stage.
//   DEFAULT_WIDTH - default operand/sum width
//   add_res_t     - {carry, sum} result at the default width
package adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef struct packed {
    logic                     co;
    logic [DEFAULT_WIDTH-1:0] s;
  } add_res_t;

endpackage

// File: rtl/fa_cell.sv
// fa_cell: 1-bit combinational full adder.
//   a, b, ci - addend bits and carry-in
//   s, co    - sum bit and carry-out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/adder_dual_reg.sv
// adder_dual_reg: registered adder that computes the sum twice (full-adder
// ripple chain and a single wide add) and flags any disagreement.
//   clk, rst         - clock, synchronous active-high reset
//   in_valid, a, b, ci - operands, sampled only when in_valid=1
//   s_inst, co_inst  - registered ripple-chain result
//   s_mbit, co_mbit  - registered wide-add result
//   out_valid        - registered results valid this cycle
//   mismatch         - the two results differ (held while idle)
//   err_sticky       - any mismatch seen since the last reset
module adder_dual_reg
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s_inst,
  output logic             co_inst,
  output logic [WIDTH-1:0] s_mbit,
  output logic             co_mbit,
  output logic             out_valid,
  output logic             mismatch,
  output logic             err_sticky
);

  typedef struct packed {
    logic             co;
    logic [WIDTH-1:0] s;
  } res_t;

  // ripple chain: c[i] feeds cell i, c[WIDTH] is the final carry
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_chain;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s_chain[i]),
      .co (c[i+1])
    );
  end

  // wide add, zero-extended so the MSB is the carry
  logic [WIDTH:0] sum_w;
  assign sum_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

  res_t res_inst, res_mbit;
  logic mism_nxt;

  assign res_inst = '{co: c[WIDTH], s: s_chain};
  assign res_mbit = '{co: sum_w[WIDTH], s: sum_w[WIDTH-1:0]};
  assign mism_nxt = (res_inst != res_mbit);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_inst     <= '0;
      co_inst    <= 1'b0;
      s_mbit     <= '0;
      co_mbit    <= 1'b0;
      out_valid  <= 1'b0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // idle cycles hold results, so unknown idle operands never reach outputs
      if (in_valid) begin
        s_inst     <= res_inst.s;
        co_inst    <= res_inst.co;
        s_mbit     <= res_mbit.s;
        co_mbit    <= res_mbit.co;
        mismatch   <= mism_nxt;
        err_sticky <= err_sticky | mism_nxt;
      end
    end
  end

endmodule

// File: tb/tb_adder_dual_reg.sv
module tb_adder_dual_reg;
  import adder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a, b;
  logic       ci;
  logic [3:0] s_inst, s_mbit;
  logic       co_inst, co_mbit, out_valid, mismatch, err_sticky;

  int checks = 0;
  int failures = 0;

  adder_dual_reg #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .ci         (ci),
    .s_inst     (s_inst),
    .co_inst    (co_inst),
    .s_mbit     (s_mbit),
    .co_mbit    (co_mbit),
    .out_valid  (out_valid),
    .mismatch   (mismatch),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  // apply inputs, take one rising edge, sample 1 time unit later
  task automatic step(input logic r, input logic v, input logic [3:0] ta,
                      input logic [3:0] tb_, input logic tci);
    rst = r; in_valid = v; a = ta; b = tb_; ci = tci;
    @(posedge clk);
    #1;
  endtask

  // observed outputs packed as {co_inst,s_inst,co_mbit,s_mbit,out_valid,mismatch,err_sticky}
  function automatic logic [12:0] obs();
    return {co_inst, s_inst, co_mbit, s_mbit, out_valid, mismatch, err_sticky};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      checks++;
      if (obs() !== 13'h0) begin
        failures++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, obs(), 13'h0);
      end
    end
  endtask

  task automatic test_directed();
    logic [3:0] va [4] = '{4'd9, 4'd7, 4'd15, 4'd0};
    logic [3:0] vb [4] = '{4'd8, 4'd8, 4'd15, 4'd0};
    logic       vc [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    add_res_t   ex [4] = '{'{1'b1, 4'd2}, '{1'b1, 4'd0}, '{1'b1, 4'd15}, '{1'b0, 4'd0}};
    logic [12:0] exp_o;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, va[i], vb[i], vc[i]);
      exp_o = {ex[i].co, ex[i].s, ex[i].co, ex[i].s, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs() !== exp_o) begin
        failures++;
        $display("FAIL directed[%0d] got=%h exp=%h", i, obs(), exp_o);
      end
    end
  endtask

  task automatic test_sweep();
    int sum;
    logic [12:0] exp_o;
    for (int k = 0; k < 512; k++) begin
      step(1'b0, 1'b1, 4'(k[7:4]), 4'(k[3:0]), k[8]);
      sum = k[7:4] + k[3:0] + int'(k[8]);
      exp_o = {sum > 15, 4'(sum % 16), sum > 15, 4'(sum % 16), 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs() !== exp_o) begin
        failures++;
        $display("FAIL sweep ci=%0d a=%0d b=%0d got=%h exp=%h", k[8], k[7:4], k[3:0], obs(), exp_o);
      end
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL sweep_sticky got=%b exp=0", err_sticky);
    end
  endtask

  task automatic test_hold();
    logic [12:0] exp_o;
    step(1'b0, 1'b1, 4'd3, 4'd4, 1'b0);
    exp_o = {1'b0, 4'd7, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp_o) begin
      failures++;
      $display("FAIL hold_load got=%h exp=%h", obs(), exp_o);
    end
    exp_o = {1'b0, 4'd7, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'(4'd9 + i), 4'(4'd12 - i), 1'b1);
      checks++;
      if (obs() !== exp_o) begin
        failures++;
        $display("FAIL hold[%0d] got=%h exp=%h", i, obs(), exp_o);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [12:0] exp_o;
    step(1'b0, 1'b1, 4'd2, 4'd3, 1'b0);
    step(1'b1, 1'b1, 4'd5, 4'd6, 1'b0);
    checks++;
    if (obs() !== 13'h0) begin
      failures++;
      $display("FAIL midrst_clear got=%h exp=%h", obs(), 13'h0);
    end
    step(1'b0, 1'b1, 4'd1, 4'd1, 1'b0);
    exp_o = {1'b0, 4'd2, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp_o) begin
      failures++;
      $display("FAIL midrst_first got=%h exp=%h", obs(), exp_o);
    end
  endtask

  task automatic test_err_inject();
    logic [12:0] exp_o;
    // 1+1+0 = 2 on both paths; chain forced to 3 (bit 0 flipped)
    rst = 1'b0; in_valid = 1'b1; a = 4'd1; b = 4'd1; ci = 1'b0;
    force dut.s_chain = 4'b0011;
    @(posedge clk);
    #1;
    exp_o = {1'b0, 4'd3, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1};
    checks++;
    if (obs() !== exp_o) begin
      failures++;
      $display("FAIL inject got=%h exp=%h", obs(), exp_o);
    end
    release dut.s_chain;
    step(1'b0, 1'b1, 4'd1, 4'd1, 1'b0);
    exp_o = {1'b0, 4'd2, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1};
    checks++;
    if (obs() !== exp_o) begin
      failures++;
      $display("FAIL sticky_hold got=%h exp=%h", obs(), exp_o);
    end
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    checks++;
    if (err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL sticky_idle got=%b exp=1", err_sticky);
    end
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    checks++;
    if (obs() !== 13'h0) begin
      failures++;
      $display("FAIL sticky_rst got=%h exp=%h", obs(), 13'h0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0;
    test_reset();
    test_directed();
    test_sweep();
    test_hold();
    test_reset_midstream();
    test_err_inject();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
